// File: rtl/vote_logger_if.sv
// vote_logger_if: groups the voting-panel signals of vote_logger.
//   master : drives mode, valid_vote, sel; observes the result/status outputs
//   slave  : the vote_logger itself
// Ports carried:
//   mode        0 = voting, 1 = result display
//   valid_vote  one request bit per candidate (1-cycle pulse = one request)
//   sel         candidate index for the result display
//   vote_ack    1-cycle pulse, vote counted
//   reject      1-cycle pulse, vote request discarded
//   busy        high while the logger is warming up or locked out
//   leds        tally of candidate sel in result mode, else 0
//   total       saturating sum of all accepted votes
//   state_dbg   current FSM state encoding, for observation only
// NUM_CAND / COUNT_W must match the parameters of the attached vote_logger.
//
// Handshake: there is no ready signal. A request is any cycle with a nonzero
// valid_vote; the cycle after it carries exactly one of vote_ack, reject, or
// neither (request ignored). vote_ack and reject are never high together.
interface vote_logger_if #(
  parameter int NUM_CAND = 4,
  parameter int COUNT_W  = 8
);
  logic                mode;
  logic [NUM_CAND-1:0] valid_vote;
  logic [2:0]          sel;
  logic                vote_ack;
  logic                reject;
  logic                busy;
  logic [COUNT_W-1:0]  leds;
  logic [COUNT_W+2:0]  total;
  logic [1:0]          state_dbg;

  modport master (
    output mode, valid_vote, sel,
    input  vote_ack, reject, busy, leds, total, state_dbg
  );

  modport slave (
    input  mode, valid_vote, sel,
    output vote_ack, reject, busy, leds, total, state_dbg
  );
endinterface

// File: rtl/vote_logger.sv
// vote_logger: per-candidate saturating vote counter with a post-vote lockout.
// Ports:
//   clock  single clock, rising edge
//   reset  synchronous, active-high
//   bus    vote_logger_if.slave (mode, valid_vote, sel in; vote_ack, reject,
//          busy, leds, total, state_dbg out)
// States: WARMUP (one cycle after reset, swallows the reset-release pulse of
// the button stages), IDLE (accepts a single-candidate vote), LOCK (LOCKOUT
// cycles during which every voting-mode request is rejected).
// All outputs are registered.
module vote_logger #(
  parameter int NUM_CAND = 4,
  parameter int COUNT_W  = 8,
  parameter int LOCKOUT  = 16
) (
  input  logic          clock,
  input  logic          reset,
  vote_logger_if.slave  bus
);
  localparam int TOT_W = COUNT_W + 3;
  localparam int CNT_W = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
  localparam int IDX_W = $clog2(NUM_CAND);

  localparam logic [NUM_CAND-1:0] VOTE_ONE  = NUM_CAND'(1);
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_LOAD  = CNT_W'(LOCKOUT - 1);
  localparam logic [COUNT_W-1:0]  TALLY_ONE = COUNT_W'(1);
  localparam logic [COUNT_W-1:0]  TALLY_MAX = '1;
  localparam logic [TOT_W-1:0]    TOT_ONE   = TOT_W'(1);
  localparam logic [TOT_W-1:0]    TOT_MAX   = '1;
  localparam logic [3:0]          SEL_LIM   = 4'(NUM_CAND);

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    IDLE   = 2'd1,
    LOCK   = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   lock_cnt, lock_cnt_next;
  logic [COUNT_W-1:0] tally [NUM_CAND];
  logic [TOT_W-1:0]   total_q;

  logic               any_vote, one_hot;
  logic [IDX_W-1:0]   vote_idx;
  logic               accept, reject_next;
  logic [COUNT_W-1:0] leds_next;

  // Request decode: exactly one bit set <=> nonzero and clearing the lowest
  // set bit leaves zero.
  always_comb begin
    any_vote = |bus.valid_vote;
    one_hot  = any_vote && ((bus.valid_vote & (bus.valid_vote - VOTE_ONE)) == '0);
    vote_idx = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (bus.valid_vote[i]) vote_idx = IDX_W'(i);
    end
  end

  // FSM next-state and per-cycle decisions.
  always_comb begin
    state_next    = state;
    lock_cnt_next = lock_cnt;
    accept        = 1'b0;
    reject_next   = 1'b0;
    case (state)
      WARMUP: state_next = IDLE;
      IDLE: begin
        if (!bus.mode) begin
          if (one_hot) begin
            accept        = 1'b1;
            state_next    = LOCK;
            lock_cnt_next = CNT_LOAD;
          end else if (any_vote) begin
            reject_next = 1'b1;
          end
        end
      end
      LOCK: begin
        // mode only gates the reject; the countdown runs regardless.
        if (!bus.mode && any_vote) reject_next = 1'b1;
        if (lock_cnt == '0) state_next = IDLE;
        else                lock_cnt_next = lock_cnt - CNT_ONE;
      end
      default: state_next = WARMUP;
    endcase
  end

  // Result display; out-of-range sel shows 0.
  always_comb begin
    leds_next = '0;
    if (bus.mode && ({1'b0, bus.sel} < SEL_LIM)) leds_next = tally[bus.sel[IDX_W-1:0]];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= WARMUP;
      lock_cnt <= '0;
    end else begin
      state    <= state_next;
      lock_cnt <= lock_cnt_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
      total_q      <= '0;
      bus.vote_ack <= 1'b0;
      bus.reject   <= 1'b0;
      bus.busy     <= 1'b1;
      bus.leds     <= '0;
    end else begin
      bus.vote_ack <= accept;
      bus.reject   <= reject_next;
      bus.busy     <= (state_next != IDLE);
      bus.leds     <= leds_next;
      // A vote for a saturated candidate is acked but changes no count.
      if (accept && (tally[vote_idx] != TALLY_MAX)) begin
        tally[vote_idx] <= tally[vote_idx] + TALLY_ONE;
        if (total_q != TOT_MAX) total_q <= total_q + TOT_ONE;
      end
    end
  end

  assign bus.total     = total_q;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_vote_logger.sv
module tb_vote_logger;
  localparam int NUM_CAND  = 4;
  localparam int COUNT_W   = 8;
  localparam int LOCKOUT   = 16;
  localparam int TOT_W     = COUNT_W + 3;
  localparam int TALLY_MAX = (1 << COUNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  vote_logger_if #(.NUM_CAND(NUM_CAND), .COUNT_W(COUNT_W)) bus ();

  vote_logger #(.NUM_CAND(NUM_CAND), .COUNT_W(COUNT_W), .LOCKOUT(LOCKOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];          // expected {vote_ack, reject} per request
  int model_tally [NUM_CAND];
  int model_total;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_CAND; i++) model_tally[i] = 0;
    model_total = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n, input logic [NUM_CAND-1:0] v);
    reset          = 1'b1;
    bus.valid_vote = v;
    bus.mode       = 1'b0;
    bus.sel        = 3'd0;
    repeat (n) step();
    model_clear();
  endtask

  // Drive one request cycle and check the response in the following cycle.
  task automatic vote(input logic [NUM_CAND-1:0] v, input logic exp_ack,
                      input logic exp_rej, input string name);
    logic [1:0] e;
    int idx;
    exp_q.push_back({exp_ack, exp_rej});
    if (exp_ack) begin
      idx = 0;
      for (int i = 0; i < NUM_CAND; i++) if (v[i]) idx = i;
      if (model_tally[idx] < TALLY_MAX) begin
        model_tally[idx]++;
        model_total++;
      end
    end
    bus.valid_vote = v;
    step();
    bus.valid_vote = '0;
    e = exp_q.pop_front();
    checks++;
    if ({bus.vote_ack, bus.reject} !== e) begin
      errors++;
      $display("FAIL %s ack_rej got %b expected %b", name, {bus.vote_ack, bus.reject}, e);
    end
    checks++;
    if (bus.total !== TOT_W'(model_total)) begin
      errors++;
      $display("FAIL %s total got %0d expected %0d", name, bus.total, model_total);
    end
  endtask

  // Count cycles while busy is sampled high, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 60) begin
      n++;
      step();
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL wait_idle timeout busy still %b", bus.busy);
    end
  endtask

  task automatic check_lock_len(input int exp_n, input string name);
    int n;
    wait_idle(n);
    checks++;
    if (n !== exp_n) begin
      errors++;
      $display("FAIL %s busy_cycles got %0d expected %0d", name, n, exp_n);
    end
  endtask

  task automatic check_tallies(input string name);
    bus.mode = 1'b1;
    for (int i = 0; i < NUM_CAND; i++) begin
      bus.sel = 3'(i);
      step();
      checks++;
      if (bus.leds !== COUNT_W'(model_tally[i])) begin
        errors++;
        $display("FAIL %s leds[%0d] got %0d expected %0d", name, i, bus.leds, model_tally[i]);
      end
    end
    bus.mode = 1'b0;
    step();
    checks++;
    if (bus.leds !== '0) begin
      errors++;
      $display("FAIL %s leds_voting got %0d expected 0", name, bus.leds);
    end
  endtask

  task automatic check_sig(input logic got, input logic expv, input string name);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, got, expv);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset(3, 4'b1111);
    check_sig(bus.vote_ack, 1'b0, "rst_ack");
    check_sig(bus.reject,   1'b0, "rst_reject");
    check_sig(bus.busy,     1'b1, "rst_busy");
    check_sig(bus.leds == '0,  1'b1, "rst_leds");
    check_sig(bus.total == '0, 1'b1, "rst_total");
    // Release with all buttons still high for the WARMUP cycle.
    reset = 1'b0;
    step();
    bus.valid_vote = '0;
    check_sig(bus.vote_ack, 1'b0, "warmup_ack");
    check_sig(bus.reject,   1'b0, "warmup_reject");
    check_sig(bus.busy,     1'b0, "warmup_busy_fall");
    step();
    check_sig(bus.reject,   1'b0, "warmup_reject_late");
    check_tallies("warmup_tallies");
  endtask

  task automatic test_single_vote();
    vote(4'b0010, 1'b1, 1'b0, "single_vote");
    check_lock_len(LOCKOUT, "single_lock");
    check_tallies("single_tallies");
  endtask

  task automatic test_lock_reject();
    int n;
    vote(4'b0001, 1'b1, 1'b0, "lockrej_first");
    repeat (4) step();
    vote(4'b0100, 1'b0, 1'b1, "lockrej_cycle5");
    wait_idle(n);
    vote(4'b0100, 1'b1, 1'b0, "lockrej_after");
    check_lock_len(LOCKOUT, "lockrej_lock");
    check_tallies("lockrej_tallies");
  endtask

  task automatic test_multi();
    vote(4'b1001, 1'b0, 1'b1, "multi_1001");
    check_sig(bus.busy, 1'b0, "multi_busy");
    vote(4'b0111, 1'b0, 1'b1, "multi_0111");
    check_sig(bus.busy, 1'b0, "multi_busy2");
  endtask

  task automatic test_result_mode_ignore();
    bus.mode = 1'b1;
    vote(4'b0001, 1'b0, 1'b0, "result_ignore");
    bus.mode = 1'b0;
    check_sig(bus.busy, 1'b0, "result_ignore_busy");
  endtask

  task automatic test_mode_in_lock();
    vote(4'b1000, 1'b1, 1'b0, "modelock_vote");
    bus.mode = 1'b1;
    vote(4'b0100, 1'b0, 1'b0, "modelock_ignored");
    bus.mode = 1'b0;
    check_lock_len(LOCKOUT - 1, "modelock_len");
    check_tallies("modelock_tallies");
  endtask

  task automatic test_back_to_back();
    vote(4'b0001, 1'b1, 1'b0, "b2b_first");
    vote(4'b0010, 1'b0, 1'b1, "b2b_lock_cycle1");
    repeat (14) step();
    vote(4'b0010, 1'b0, 1'b1, "b2b_lock_last");
    check_sig(bus.busy, 1'b0, "b2b_busy_low");
    vote(4'b0010, 1'b1, 1'b0, "b2b_first_idle");
    check_lock_len(LOCKOUT, "b2b_lock");
    check_tallies("b2b_tallies");
  endtask

  task automatic test_saturation();
    do_reset(2, '0);
    reset = 1'b0;
    step();
    for (int k = 0; k < 300; k++) begin
      vote(4'b0001, 1'b1, 1'b0, "sat_vote");
      check_lock_len(LOCKOUT, "sat_lock");
    end
    bus.mode = 1'b1;
    bus.sel  = 3'd0;
    step();
    check_sig(bus.leds == 8'd255,   1'b1, "sat_leds255");
    check_sig(bus.total == 11'd255, 1'b1, "sat_total255");
    bus.sel = 3'd5;
    step();
    check_sig(bus.leds == '0, 1'b1, "sat_sel5");
    bus.sel = 3'd7;
    step();
    check_sig(bus.leds == '0, 1'b1, "sat_sel7");
    bus.mode = 1'b0;
    bus.sel  = 3'd0;
    step();
    check_sig(bus.leds == '0, 1'b1, "sat_voting_leds");
  endtask

  task automatic test_reset_mid_lock();
    int n;
    do_reset(2, '0);
    reset = 1'b0;
    step();
    vote(4'b0001, 1'b1, 1'b0, "midrst_v1");
    wait_idle(n);
    vote(4'b0010, 1'b1, 1'b0, "midrst_v2");
    wait_idle(n);
    vote(4'b0100, 1'b1, 1'b0, "midrst_v3");
    repeat (7) step();
    reset          = 1'b1;
    bus.valid_vote = 4'b0001;
    step();
    model_clear();
    for (int k = 0; k < 2; k++) begin
      check_sig(bus.total == '0, 1'b1, "midrst_total");
      check_sig(bus.vote_ack, 1'b0, "midrst_ack");
      check_sig(bus.reject,   1'b0, "midrst_reject");
      check_sig(bus.busy,     1'b1, "midrst_busy");
      step();
    end
    reset          = 1'b0;
    bus.valid_vote = '0;
    step();
    check_sig(bus.busy, 1'b0, "midrst_release_busy");
    check_tallies("midrst_tallies");
    vote(4'b1000, 1'b1, 1'b0, "midrst_revote");
    check_lock_len(LOCKOUT, "midrst_lock");
  endtask

  // vote_ack and reject must never coincide.
  always @(negedge clock) begin
    if (reset === 1'b0) begin
      checks++;
      if (bus.vote_ack === 1'b1 && bus.reject === 1'b1) begin
        errors++;
        $display("FAIL ack_reject_overlap got 11 expected not both high");
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    bus.mode       = 1'b0;
    bus.valid_vote = '0;
    bus.sel        = 3'd0;
    model_clear();
    test_reset();
    test_single_vote();
    test_lock_reject();
    test_multi();
    test_result_mode_ignore();
    test_mode_in_lock();
    test_back_to_back();
    test_saturation();
    test_reset_mid_lock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vote_logger.md
VOTE_LOGGER -- requirements
Module: vote_logger

Interface
REQ-001 Parameter NUM_CAND, default 4, number of candidates; the legal range is 2..8.
REQ-002 Parameter COUNT_W, default 8, width of each per-candidate tally.
REQ-003 Parameter LOCKOUT, default 16, number of clock cycles during which votes are blocked after an accepted vote; the legal range is >= 1.
REQ-004 The ports SHALL be as follows, one per line: name, direction, width, meaning.
- clock  input  1  single clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = voting, 1 = result display.
- valid_vote  input  NUM_CAND  one bit per candidate, driven by that candidate's button stage; a 1-cycle pulse is one vote request.
- sel  input  3  candidate index shown in result mode; only the low bits are used.
- vote_ack  output  1  1-cycle pulse when a vote is counted.
- reject  output  1  1-cycle pulse when a vote request is discarded.
- busy  output  1  high while in WARMUP or LOCK.
- leds  output  COUNT_W  tally of candidate sel in result mode; 0 in voting mode.
- total  output  COUNT_W+3  sum of all accepted votes.
REQ-005 All outputs SHALL be registered.

Function
REQ-006 The block SHALL implement three states: WARMUP, IDLE and LOCK.
REQ-007 WARMUP SHALL last exactly 1 cycle after reset deasserts; all valid_vote bits are ignored there (no ack, no reject), absorbing the upstream reset-release pulse; the next state is IDLE.
REQ-008 In IDLE with mode=0 and exactly one valid_vote bit high, the block SHALL do the following:
- increment that candidate's tally;
- increment total;
- pulse vote_ack on the next cycle;
- enter LOCK.
REQ-009 In IDLE with mode=0 and two or more valid_vote bits high in the same cycle, the block SHALL count nothing, pulse reject on the next cycle, and remain in IDLE.
REQ-010 In IDLE with mode=1, any valid_vote bit SHALL be ignored: no count, no ack, no reject.
REQ-011 LOCK SHALL last exactly LOCKOUT cycles, timed by a down-counter loaded on entry; the next state is IDLE.
REQ-012 Any valid_vote bit high during LOCK with mode=0 SHALL pulse reject on the next cycle and count nothing.
REQ-013 A mode change during LOCK SHALL NOT shorten or extend the lockout.
REQ-014 Tallies SHALL saturate at 2^COUNT_W-1, and total SHALL saturate at 2^(COUNT_W+3)-1.
REQ-015 A vote for a saturated candidate SHALL still be acked and still enter LOCK, but neither that tally nor total SHALL change.
REQ-016 With mode=1, leds SHALL equal tally[sel] one cycle after sel or mode changes. If sel >= NUM_CAND, leds SHALL be 0.
REQ-017 total SHALL update in the same cycle that the tally updates.
REQ-018 vote_ack and reject SHALL never be high together.

Reset
REQ-019 While reset=1, the following SHALL hold:
- all tallies = 0, total = 0;
- leds = 0, vote_ack = 0, reject = 0;
- busy = 1;
- state = WARMUP.
REQ-020 Reset SHALL take priority over all other inputs. An assertion of reset mid-LOCK SHALL clear the tallies and the lock counter on the next edge.
REQ-021 valid_vote SHALL be ignored during reset and in the single WARMUP cycle after reset.

Verification
REQ-022 Reset release with valid_vote=4'b1111 held for 1 cycle -> no ack, no reject, all tallies 0, busy falls after 1 cycle.
REQ-023 mode=0, pulse valid_vote=4'b0010 -> vote_ack 1 cycle later, tally[1]=1, total=1, busy high for 16 cycles.
REQ-024 Pulse 4'b0100 at LOCK cycle 5 -> reject pulse, tally[2]=0; a pulse after 16 cycles -> accepted, tally[2]=1.
REQ-025 Pulse 4'b1001 in IDLE -> reject, total unchanged, state stays IDLE with busy=0.
REQ-026 300 separated votes for candidate 0, then mode=1 and sel=0 -> leds=255 and total=255; sel=5 -> leds=0.
REQ-027 Assert reset at LOCK cycle 8 after 3 votes -> all tallies and total are 0, vote_ack=0 and busy=1 while reset is held.
